// File: rtl/zeptron_pkg.sv
// zeptron_pkg: shared widths, word type and writeback-arbiter state encoding
package zeptron_pkg;
   localparam int REG_W = 5;
   localparam int XLEN = 32;
   typedef enum logic [1:0] {IDLE, B_WAIT, STARVED} arb_state_e;
   typedef logic [XLEN-1:0] word_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback, LL-unit, decode and register-file write-port signals
interface regfile_wb_arbiter_if;
   import zeptron_pkg::*;
   logic             a_valid;
   logic [REG_W-1:0] a_rd;
   word_t            a_data;
   logic             b_valid;
   logic             b_ready;
   logic [REG_W-1:0] b_rd;
   word_t            b_data;
   logic             iss_valid;
   logic [REG_W-1:0] iss_rd;
   logic [REG_W-1:0] dec_rs1;
   logic [REG_W-1:0] dec_rs2;
   logic [REG_W-1:0] dec_rd;
   logic             dec_stall;
   logic             starve_hold;
   logic             we3;
   logic [REG_W-1:0] wa3;
   word_t            wd3;
   modport slave (
      input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
      input  iss_valid, iss_rd, dec_rs1, dec_rs2, dec_rd,
      output b_ready, dec_stall, starve_hold, we3, wa3, wd3
   );
   modport master (
      output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
      output iss_valid, iss_rd, dec_rs1, dec_rs2, dec_rd,
      input  b_ready, dec_stall, starve_hold, we3, wa3, wd3
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: busy bit per register with an LL-unit result outstanding
module regfile_scoreboard
   import zeptron_pkg::*;
#(
   parameter int NREGS = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             iss_valid,
   input  logic [REG_W-1:0] iss_rd,
   input  logic             clr_en,
   input  logic [REG_W-1:0] clr_rd,
   input  logic [REG_W-1:0] rs1,
   input  logic [REG_W-1:0] rs2,
   input  logic [REG_W-1:0] rd,
   output logic             stall
);
   logic [NREGS-1:0] busy, set_m, clr_m;
   always_comb begin
      set_m = '0;
      clr_m = '0;
      set_m[iss_rd] = iss_valid;
      clr_m[clr_rd] = clr_en;
   end
   // set applied after clear so a re-issued rd stays pending; bit 0 forced low
   always_ff @(posedge clk or negedge reset)
      if (!reset) busy <= '0;
      else busy <= ((busy & ~clr_m) | set_m) & ~NREGS'(1);
   assign stall = busy[rs1] | busy[rs2] | busy[rd] | (iss_valid & busy[iss_rd]);
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between writeback (A) and the LL unit (B)
module regfile_wb_arbiter
   import zeptron_pkg::*;
#(
   parameter int MAX_WAIT = 4,
   parameter int NREGS = 32
) (
   input logic                  clk,
   input logic                  reset,
   regfile_wb_arbiter_if.slave  bus
);
   localparam int CW = $clog2(MAX_WAIT + 1);
   arb_state_e    state;
   logic [CW-1:0] wait_cnt, cnt_inc;
   logic          starve_hold, gnt_a, gnt_b, refused, at_max, stall;
   always_comb begin
      gnt_a = bus.a_valid & ~starve_hold;
      gnt_b = bus.b_valid & (starve_hold | ~bus.a_valid);
      refused = bus.b_valid & ~gnt_b & (state != STARVED);
      cnt_inc = wait_cnt + 1'b1;
      at_max = cnt_inc == CW'(MAX_WAIT);
   end
   assign bus.b_ready = gnt_b;
   assign bus.starve_hold = starve_hold;
   assign bus.dec_stall = stall;
   assign bus.we3 = gnt_a ? |bus.a_rd : gnt_b & |bus.b_rd;
   assign bus.wa3 = gnt_a ? bus.a_rd : gnt_b ? bus.b_rd : '0;
   assign bus.wd3 = gnt_a ? bus.a_data : gnt_b ? bus.b_data : '0;
   // any cycle B is not refused (transfer, dropped valid, or starved grant) returns to IDLE
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         wait_cnt <= '0;
         starve_hold <= 1'b0;
      end else begin
         state <= refused ? (at_max ? STARVED : B_WAIT) : IDLE;
         wait_cnt <= refused ? cnt_inc : '0;
         starve_hold <= refused & at_max;
      end
   regfile_scoreboard #(.NREGS(NREGS)) u_sb (
      .clk       (clk),
      .reset     (reset),
      .iss_valid (bus.iss_valid),
      .iss_rd    (bus.iss_rd),
      .clr_en    (gnt_b),
      .clr_rd    (bus.b_rd),
      .rs1       (bus.dec_rs1),
      .rs2       (bus.dec_rs2),
      .rd        (bus.dec_rd),
      .stall     (stall)
   );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed spec scenarios plus random traffic against a behavioural model
module tb_regfile_wb_arbiter;
   import zeptron_pkg::*;
   localparam int MAX_WAIT = 4;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int total = 0;
   int bad = 0;
   bit busy_m [32];
   int refused = 0;
   bit sh_m = 1'b0;
   logic o_we, o_br, o_st, o_sh;
   logic [4:0] o_wa;
   logic [31:0] o_wd;
   regfile_wb_arbiter_if bus();
   regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT), .NREGS(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic idle();
      bus.a_valid = 0; bus.a_rd = 0; bus.a_data = 0;
      bus.b_valid = 0; bus.b_rd = 0; bus.b_data = 0;
      bus.iss_valid = 0; bus.iss_rd = 0;
      bus.dec_rs1 = 0; bus.dec_rs2 = 0; bus.dec_rd = 0;
   endtask
   task automatic model_clear();
      foreach (busy_m[i]) busy_m[i] = 1'b0;
      refused = 0;
      sh_m = 1'b0;
   endtask
   // winner: 0 none, 1 pipeline, 2 LL unit
   task automatic step();
      int who;
      bit we_e, st_e;
      logic [4:0] wa_e;
      logic [31:0] wd_e;
      @(negedge clk);
      who = sh_m ? (bus.b_valid ? 2 : 0) : bus.a_valid ? 1 : bus.b_valid ? 2 : 0;
      we_e = (who == 1 && bus.a_rd != 0) || (who == 2 && bus.b_rd != 0);
      wa_e = who == 1 ? bus.a_rd : who == 2 ? bus.b_rd : 5'd0;
      wd_e = who == 1 ? bus.a_data : who == 2 ? bus.b_data : 32'd0;
      st_e = busy_m[bus.dec_rs1] | busy_m[bus.dec_rs2] | busy_m[bus.dec_rd] |
             (bus.iss_valid & busy_m[bus.iss_rd]);
      o_we = bus.we3; o_wa = bus.wa3; o_wd = bus.wd3;
      o_br = bus.b_ready; o_st = bus.dec_stall; o_sh = bus.starve_hold;
      check("we3", 64'(o_we), 64'(we_e));
      check("wa3", 64'(o_wa), 64'(wa_e));
      check("wd3", 64'(o_wd), 64'(wd_e));
      check("b_ready", 64'(o_br), 64'(who == 2));
      check("dec_stall", 64'(o_st), 64'(st_e));
      check("starve_hold", 64'(o_sh), 64'(sh_m));
      @(posedge clk);
      if (who == 2) busy_m[bus.b_rd] = 1'b0;
      if (bus.iss_valid && bus.iss_rd != 0) busy_m[bus.iss_rd] = 1'b1;
      refused = (bus.b_valid && who != 2) ? refused + 1 : 0;
      sh_m = refused == MAX_WAIT;
      #1;
   endtask
   initial begin
      idle();
      model_clear();
      #2;
      check("rst_we3", 64'(bus.we3), 64'd0);
      check("rst_b_ready", 64'(bus.b_ready), 64'd0);
      check("rst_stall", 64'(bus.dec_stall), 64'd0);
      check("rst_starve", 64'(bus.starve_hold), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      // A has priority; B keeps being refused until the starvation grant
      bus.a_valid = 1; bus.a_rd = 5; bus.a_data = 32'hDEADBEEF;
      bus.b_valid = 1; bus.b_rd = 7; bus.b_data = 32'h1234_5678;
      step();
      check("t2_we3", 64'(o_we), 64'd1);
      check("t2_wa3", 64'(o_wa), 64'd5);
      check("t2_wd3", 64'(o_wd), 64'hDEADBEEF);
      check("t2_b_ready", 64'(o_br), 64'd0);
      for (int c = 2; c <= 4; c++) begin
         bus.a_rd = 5'(6 + c);
         bus.a_data = 32'(c);
         step();
         check("t3_refused", 64'(o_br), 64'd0);
      end
      check("t3_hold_c5", 64'(bus.starve_hold), 64'd1);
      bus.a_valid = 0;
      step();
      check("t3_b_wa3", 64'(o_wa), 64'd7);
      check("t3_b_we3", 64'(o_we), 64'd1);
      check("t3_b_ready", 64'(o_br), 64'd1);
      bus.b_valid = 0; bus.a_valid = 1;
      step();
      check("t3_idle", 64'(o_sh), 64'd0);
      idle();
      bus.iss_valid = 1; bus.iss_rd = 9;
      step();
      idle();
      bus.dec_rs2 = 9;
      step();
      check("t4_stall1", 64'(o_st), 64'd1);
      step();
      check("t4_stall2", 64'(o_st), 64'd1);
      bus.b_valid = 1; bus.b_rd = 9; bus.b_data = 32'hCAFE0009;
      step();
      check("t4_stall_retire", 64'(o_st), 64'd1);
      bus.b_valid = 0;
      step();
      check("t4_released", 64'(o_st), 64'd0);
      idle();
      bus.iss_valid = 1; bus.iss_rd = 3;
      bus.b_valid = 1; bus.b_rd = 3; bus.b_data = 32'h33;
      step();
      check("t5_b_ready", 64'(o_br), 64'd1);
      idle();
      bus.dec_rs1 = 3;
      bus.a_valid = 1; bus.a_rd = 0; bus.a_data = 32'h55;
      step();
      check("t5_set_wins", 64'(o_st), 64'd1);
      check("t5_x0_we3", 64'(o_we), 64'd0);
      idle();
      bus.b_valid = 1; bus.b_rd = 3;
      step();
      idle();
      for (int c = 0; c < 500; c++) begin
         if (!bus.b_valid || o_br) begin
            bus.b_valid = $urandom_range(0, 2) != 0;
            bus.b_rd = 5'($urandom_range(0, 7));
            bus.b_data = $urandom;
         end
         bus.a_valid = !sh_m && $urandom_range(0, 3) != 0;
         bus.a_rd = 5'($urandom_range(0, 31));
         bus.a_data = $urandom;
         bus.iss_valid = $urandom_range(0, 3) == 0;
         bus.iss_rd = 5'($urandom_range(0, 7));
         bus.dec_rs1 = 5'($urandom_range(0, 7));
         bus.dec_rs2 = 5'($urandom_range(0, 7));
         bus.dec_rd = 5'($urandom_range(0, 7));
         step();
      end
      // async reset while starved with a busy register outstanding
      idle();
      bus.iss_valid = 1; bus.iss_rd = 4;
      step();
      idle();
      bus.dec_rs1 = 4;
      bus.a_valid = 1; bus.b_valid = 1; bus.b_rd = 7; bus.b_data = 32'h77;
      for (int c = 0; c < MAX_WAIT; c++) step();
      check("t6_hold_pre", 64'(bus.starve_hold), 64'd1);
      check("t6_stall_pre", 64'(bus.dec_stall), 64'd1);
      bus.a_valid = 0; bus.b_valid = 0;
      #2;
      reset = 1'b0;
      model_clear();
      #1;
      check("t6_hold_rst", 64'(bus.starve_hold), 64'd0);
      check("t6_stall_rst", 64'(bus.dec_stall), 64'd0);
      check("t6_we3_rst", 64'(bus.we3), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      bus.b_valid = 1; bus.b_rd = 7;
      step();
      check("t6_idle_b_grant", 64'(o_br), 64'd1);
      idle();
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
